// File: rtl/flap_ctrl.sv
// rtl/flap_ctrl.sv - push-button flap conditioner: sync, debounce, edge detect, timed burst, cooldown
//
// Purpose:
//   Turns a raw, active-low push-button into timed flap bursts for the bird.
//   Each accepted press holds flap for FLAP_TICKS frame ticks, then locks out
//   further presses for COOLDOWN_TICKS frame ticks. flap is masked while the
//   bird is at or above the screen ceiling. Accepted presses are counted.
//
// Ports:
//   clk         in   1   system clock, all state on posedge
//   reset       in   1   asynchronous, active-low reset
//   key         in   1   raw push-button, asynchronous, active-low (0 = pressed)
//   tick        in   1   one-cycle frame-step strobe
//   enable      in   1   game running; 0 = no flaps accepted
//   bird_y0     in   N   bird top edge in pixels, 0 = top of screen
//   flap        out  1   1 = move up, 0 = fall
//   busy        out  1   1 while a burst or cooldown is in progress
//   flap_count  out  8   accepted flaps, saturating at 255

module flap_ctrl #(
   parameter int N              = 10,
   parameter int DEBOUNCE       = 4,
   parameter int FLAP_TICKS     = 8,
   parameter int COOLDOWN_TICKS = 4,
   parameter int CEIL_Y         = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key,
   input  logic         tick,
   input  logic         enable,
   input  logic [N-1:0] bird_y0,
   output logic         flap,
   output logic         busy,
   output logic [7:0]   flap_count
);

   localparam int DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int TMAX = (FLAP_TICKS > COOLDOWN_TICKS) ? FLAP_TICKS : COOLDOWN_TICKS;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [N-1:0]  CEIL      = N'(CEIL_Y);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
   localparam logic [TW-1:0] FLAP_LOAD = TW'(FLAP_TICKS);
   localparam logic [TW-1:0] COOL_LOAD = TW'(COOLDOWN_TICKS);
   localparam logic [TW-1:0] ONE       = TW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      COOL = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Synchroniser and debounce
   // ---------------------------------------------------------------
   // The sync FFs carry the raw (active-low) key level, so their reset
   // value of 1 is the released state; the pressed level is the inverse
   // of the second stage.
   logic          ks1;
   logic          ks2;
   logic          pressed;
   logic          db;
   logic          db_d;
   logic [DW-1:0] deb_cnt;
   logic          press_evt;

   assign pressed   = ~ks2;
   assign press_evt = db & ~db_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ks1     <= 1'b1;
         ks2     <= 1'b1;
         db      <= 1'b0;
         db_d    <= 1'b0;
         deb_cnt <= '0;
      end else begin
         ks1  <= key;
         ks2  <= ks1;
         db_d <= db;
         if (pressed == db) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            // level has differed for DEBOUNCE consecutive edges: accept it
            db      <= pressed;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Burst / cooldown FSM
   // ---------------------------------------------------------------
   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] tick_cnt;
   logic [TW-1:0] tick_cnt_nxt;
   logic          count_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         flap_count <= 8'd0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_cnt_nxt;
         if (count_inc && (flap_count != 8'hFF)) begin
            flap_count <= flap_count + 8'd1;
         end
      end
   end

   // A tick arriving on the same cycle a press is accepted is not counted
   // toward the burst: IDLE ignores tick entirely.
   always_comb begin
      state_nxt    = state;
      tick_cnt_nxt = tick_cnt;
      count_inc    = 1'b0;
      if (!enable) begin
         state_nxt    = IDLE;
         tick_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (press_evt) begin
                  state_nxt    = RISE;
                  tick_cnt_nxt = FLAP_LOAD;
                  count_inc    = 1'b1;
               end
            end
            RISE: begin
               if (tick) begin
                  if (tick_cnt == ONE) begin
                     state_nxt    = COOL;
                     tick_cnt_nxt = COOL_LOAD;
                  end else begin
                     tick_cnt_nxt = tick_cnt - ONE;
                  end
               end
            end
            COOL: begin
               if (tick) begin
                  if (tick_cnt == ONE) begin
                     state_nxt    = IDLE;
                     tick_cnt_nxt = '0;
                  end else begin
                     tick_cnt_nxt = tick_cnt - ONE;
                  end
               end
            end
            default: begin
               state_nxt    = IDLE;
               tick_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Ceiling masking only affects the output; the burst timer keeps running.
   always_comb begin
      flap = 1'b0;
      busy = 1'b0;
      flap = (state == RISE) && (bird_y0 > CEIL);
      busy = (state != IDLE);
   end

endmodule
